// File: rtl/iir_coef_loader.sv
// -----------------------------------------------------------------------------
// iir_coef_loader
//
// Purpose:
//   Collects a frame of REGSA_NUM+REGSB_NUM 32-bit coefficient beats from a
//   valid/ready stream into shadow registers. A complete, well-formed frame is
//   swapped into the active coefficient outputs atomically, one cycle after
//   the final beat. Malformed frames (short, long, or failing the optional
//   sign check) are rejected with an err strobe and never reach the outputs.
//
// Optional feature:
//   IIR_COEF_SIGN_CHECK_EN - when defined, every stored beat must be a proper
//   sign extension of its low COEF_SZ bits; one bad beat rejects the frame.
//   When undefined all 32 bits are stored verbatim.
//
// Ports:
//   clk      in   single clock, all logic on posedge
//   rstn     in   synchronous active-low reset
//   s_valid  in   write beat valid
//   s_data   in   coefficient word (32 bits)
//   s_last   in   final beat of a coefficient frame
//   s_ready  out  loader accepts beat (low only in COMMIT and during reset)
//   coefsA   out  active A coefficients, REGSA_NUM 32-bit slots
//   coefsB   out  active B coefficients, REGSB_NUM 32-bit slots
//   update   out  one-cycle strobe, new coefficient set active
//   err      out  one-cycle strobe, frame rejected
//   busy     out  frame partially received or commit/drain in progress
// -----------------------------------------------------------------------------
module iir_coef_loader #(
   parameter int REGSA_NUM = 2,
   parameter int REGSB_NUM = 2,
   parameter int COEF_SZ   = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   s_valid,
   input  logic [31:0]            s_data,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic [REGSA_NUM*32-1:0] coefsA,
   output logic [REGSB_NUM*32-1:0] coefsB,
   output logic                   update,
   output logic                   err,
   output logic                   busy
);

   localparam int FRAME_N = REGSA_NUM + REGSB_NUM;
   localparam int CNT_W   = $clog2(FRAME_N + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_N - 1);
   // Counter parks at N once the last slot is written; N+1 codes fit CNT_W.
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_N);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_COMMIT = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t                   state_r;
   state_t                   state_nx_s;
   logic [CNT_W-1:0]         cnt_r;
   logic [CNT_W-1:0]         cnt_nx_s;
   logic [REGSA_NUM*32-1:0]  shadow_a_r;
   logic [REGSB_NUM*32-1:0]  shadow_b_r;
   logic [REGSA_NUM*32-1:0]  coefs_a_r;
   logic [REGSB_NUM*32-1:0]  coefs_b_r;
   logic                     update_r;
   logic                     err_r;
   logic                     busy_r;
   logic                     ready_r;
   logic                     update_nx_s;
   logic                     err_nx_s;
   logic                     busy_nx_s;
   logic                     ready_nx_s;
   logic                     accept_s;
   logic                     reject_s;
   logic                     frame_bad_s;

   // True when bits [31:COEF_SZ] all replicate bit COEF_SZ-1.
   function automatic logic sign_ext_ok(input logic [31:0] data);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if ((i >= COEF_SZ) && (data[i] != data[COEF_SZ-1])) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   assign accept_s = s_valid & ready_r;

`ifdef IIR_COEF_SIGN_CHECK_EN
   logic bad_r;
   logic beat_bad_s;

   // Flag a stored beat that is not a clean sign extension.
   always_comb begin
      beat_bad_s = 1'b0;
      if (accept_s && (state_r == ST_LOAD)) begin
         beat_bad_s = ~sign_ext_ok(s_data);
      end else begin
         beat_bad_s = 1'b0;
      end
   end

   // Include the current beat so a bad final beat rejects its own frame.
   assign frame_bad_s = bad_r | beat_bad_s;

   // Sticky per-frame bad flag, cleared whenever a frame closes.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         bad_r <= 1'b0;
      end else if (reject_s || (state_r == ST_COMMIT)) begin
         bad_r <= 1'b0;
      end else if (beat_bad_s) begin
         bad_r <= 1'b1;
      end
   end
`else
   assign frame_bad_s = 1'b0;
`endif

   // State and beat-counter register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r <= ST_LOAD;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Next-state, next-count and frame-reject decode.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      reject_s   = 1'b0;
      case (state_r)
         ST_LOAD: begin
            if (accept_s) begin
               if (cnt_r == LAST_IDX) begin
                  if (!s_last) begin
                     // Frame overruns: swallow the rest up to s_last.
                     state_nx_s = ST_DRAIN;
                     cnt_nx_s   = FULL_CNT;
                  end else if (frame_bad_s) begin
                     reject_s = 1'b1;
                     cnt_nx_s = CNT_ZERO;
                  end else begin
                     state_nx_s = ST_COMMIT;
                     cnt_nx_s   = FULL_CNT;
                  end
               end else if (s_last) begin
                  // Short frame.
                  reject_s = 1'b1;
                  cnt_nx_s = CNT_ZERO;
               end else begin
                  cnt_nx_s = cnt_r + CNT_ONE;
               end
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         ST_COMMIT: begin
            state_nx_s = ST_LOAD;
            cnt_nx_s   = CNT_ZERO;
         end
         ST_DRAIN: begin
            if (accept_s && s_last) begin
               reject_s   = 1'b1;
               state_nx_s = ST_LOAD;
               cnt_nx_s   = CNT_ZERO;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: begin
            state_nx_s = ST_LOAD;
            cnt_nx_s   = CNT_ZERO;
         end
      endcase
   end

   // Next values of the registered status outputs.
   always_comb begin
      update_nx_s = (state_r == ST_COMMIT);
      err_nx_s    = reject_s;
      busy_nx_s   = (cnt_nx_s != CNT_ZERO) || (state_nx_s != ST_LOAD);
      ready_nx_s  = (state_nx_s != ST_COMMIT);
   end

   // Shadow capture: beat j lands in the slot counted down from the top.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         shadow_a_r <= {(REGSA_NUM*32){1'b0}};
         shadow_b_r <= {(REGSB_NUM*32){1'b0}};
      end else if (accept_s && (state_r == ST_LOAD)) begin
         for (int i = 0; i < REGSA_NUM; i++) begin
            if (cnt_r == CNT_W'(REGSA_NUM - 1 - i)) begin
               shadow_a_r[i*32 +: 32] <= s_data;
            end
         end
         for (int i = 0; i < REGSB_NUM; i++) begin
            if (cnt_r == CNT_W'(FRAME_N - 1 - i)) begin
               shadow_b_r[i*32 +: 32] <= s_data;
            end
         end
      end
   end

   // Output registers; both coefficient banks flip on the COMMIT closing edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         coefs_a_r <= {(REGSA_NUM*32){1'b0}};
         coefs_b_r <= {(REGSB_NUM*32){1'b0}};
         update_r  <= 1'b0;
         err_r     <= 1'b0;
         busy_r    <= 1'b0;
         ready_r   <= 1'b0;
      end else begin
         update_r <= update_nx_s;
         err_r    <= err_nx_s;
         busy_r   <= busy_nx_s;
         ready_r  <= ready_nx_s;
         if (state_r == ST_COMMIT) begin
            coefs_a_r <= shadow_a_r;
            coefs_b_r <= shadow_b_r;
         end
      end
   end

   assign s_ready = ready_r;
   assign coefsA  = coefs_a_r;
   assign coefsB  = coefs_b_r;
   assign update  = update_r;
   assign err     = err_r;
   assign busy    = busy_r;

endmodule

// File: tb/tb_iir_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_iir_coef_loader
//
// Scoreboard bench for iir_coef_loader (REGSA_NUM=2, REGSB_NUM=2, COEF_SZ=16).
// The driver predicts each frame outcome from the beat sequence and pushes it
// into a queue just before the closing beat is accepted; a negedge monitor
// pops and compares event kind, cycle, and the active coefficient banks, and
// checks s_ready against the predicted COMMIT cycle.
// -----------------------------------------------------------------------------
module tb_iir_coef_loader;

   logic        clk;
   logic        rstn;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_last;
   logic        s_ready;
   logic [63:0] coefsA;
   logic [63:0] coefsB;
   logic        update;
   logic        err;
   logic        busy;

   iir_coef_loader #(
      .REGSA_NUM (2),
      .REGSB_NUM (2),
      .COEF_SZ   (16)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_last  (s_last),
      .s_ready (s_ready),
      .coefsA  (coefsA),
      .coefsB  (coefsB),
      .update  (update),
      .err     (err),
      .busy    (busy)
   );

   typedef struct {
      bit          is_upd;
      int          cyc;
      logic [63:0] a;
      logic [63:0] b;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        ev;
   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   bit          rst_edge = 1'b1;
   bit          mon_en = 1'b0;
   bit          exp_rdy;
   logic [63:0] cur_a = 64'h0;
   logic [63:0] cur_b = 64'h0;
   logic [31:0] fw [8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter and record of whether the last edge saw reset.
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= !rstn;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: compare outputs against the scoreboard away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_edge) begin
            cur_a = 64'h0;
            cur_b = 64'h0;
            check("rst_ready", s_ready, 64'd0);
            check("rst_update", update, 64'd0);
            check("rst_err", err, 64'd0);
         end else begin
            exp_rdy = 1'b1;
            if (exp_q.size() > 0) begin
               if (exp_q[0].is_upd && (exp_q[0].cyc == cyc + 1)) exp_rdy = 1'b0;
            end
            check("s_ready", s_ready, exp_rdy);
            if ((update === 1'b1) || (err === 1'b1)) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_event", {update, err}, 64'd0);
               end else begin
                  ev = exp_q.pop_front();
                  check("event_kind", {update, err}, ev.is_upd ? 64'd2 : 64'd1);
                  check("event_cycle", cyc, ev.cyc);
                  if (ev.is_upd) begin
                     cur_a = ev.a;
                     cur_b = ev.b;
                  end
               end
            end else if (exp_q.size() > 0) begin
               if (exp_q[0].cyc <= cyc) begin
                  ev = exp_q.pop_front();
                  check("missed_event", {update, err}, ev.is_upd ? 64'd2 : 64'd1);
               end
            end
            check("coefsA", coefsA, cur_a);
            check("coefsB", coefsB, cur_b);
         end
      end
   end

   // Drive one beat (called at a negedge); optionally push the frame outcome.
   task automatic send_beat(input logic [31:0] d, input bit last, input int gap,
                            input bit push, input bit is_upd);
      exp_t e;
      int   waited;
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      waited  = 0;
      while ((s_ready !== 1'b1) && (waited < 20)) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) begin
         check("ready_timeout", waited, 64'd0);
      end else if (push) begin
         e.is_upd = is_upd;
         e.cyc    = cyc + 1 + (is_upd ? 1 : 0);
         e.a      = {fw[0], fw[1]};
         e.b      = {fw[2], fw[3]};
         exp_q.push_back(e);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Send fw[0..n-1] with s_last on the final word, predicting the outcome.
   task automatic send_frame(input int n, input int gap);
      bit bad;
      bit drain;
      bit last;
      bit push;
      bit upd;
      bad   = 1'b0;
      drain = 1'b0;
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         push = 1'b0;
         upd  = 1'b0;
         if (!drain) begin
`ifdef IIR_COEF_SIGN_CHECK_EN
            if (fw[i][31:16] != {16{fw[i][15]}}) bad = 1'b1;
`endif
            if (i == 3) begin
               if (last) begin
                  push = 1'b1;
                  upd  = !bad;
               end else begin
                  drain = 1'b1;
               end
            end else if (last) begin
               push = 1'b1;
            end
         end else if (last) begin
            push = 1'b1;
         end
         send_beat(fw[i], last, gap, push, upd);
      end
   endtask

   initial begin
      logic [31:0] r;
      int          n;
      int          w;
      rstn    = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 32'h0;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      check("rst_busy", busy, 64'd0);
      check("rst_coefsA", coefsA, 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      // Basic frame 1..4.
      fw[0] = 32'd1; fw[1] = 32'd2; fw[2] = 32'd3; fw[3] = 32'd4;
      send_frame(4, 0);
      check("commit_busy", busy, 64'd1);
      check("commit_ready", s_ready, 64'd0);
      @(negedge clk);
      check("upd_busy", busy, 64'd0);
      check("basic_A", coefsA, 64'h00000001_00000002);
      check("basic_B", coefsB, 64'h00000003_00000004);

      // Short frame 5,6.
      fw[0] = 32'd5; fw[1] = 32'd6;
      send_frame(2, 0);
      check("short_busy", busy, 64'd0);
      @(negedge clk);
      check("short_busy_next", busy, 64'd0);

      // Overlong frame 7,8,9,A,B drained.
      fw[0] = 32'h7; fw[1] = 32'h8; fw[2] = 32'h9; fw[3] = 32'hA; fw[4] = 32'hB;
      send_frame(5, 0);
      @(negedge clk);
      check("drain_A", coefsA, 64'h00000001_00000002);

      // Frame with 3-cycle valid gaps.
      fw[0] = 32'h11; fw[1] = 32'h22; fw[2] = 32'h33; fw[3] = 32'h44;
      send_frame(4, 3);
      @(negedge clk);
      check("gap_A", coefsA, 64'h00000011_00000022);
      check("gap_B", coefsB, 64'h00000033_00000044);

      // Reset after two beats, then a normal frame.
      send_beat(32'hAA, 1'b0, 0, 1'b0, 1'b0);
      send_beat(32'hBB, 1'b0, 0, 1'b0, 1'b0);
      check("mid_busy", busy, 64'd1);
      rstn = 1'b0;
      @(negedge clk);
      check("midrst_A", coefsA, 64'd0);
      check("midrst_busy", busy, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("release_ready", s_ready, 64'd1);
      fw[0] = 32'd1; fw[1] = 32'd2; fw[2] = 32'd3; fw[3] = 32'd4;
      send_frame(4, 0);

      // Sign-extension frames, back to back with the commit above.
      fw[0] = 32'hFFFF8000; fw[1] = 32'h1; fw[2] = 32'h00018000; fw[3] = 32'h4;
      send_frame(4, 0);
      fw[0] = 32'hFFFF8000; fw[1] = 32'h1; fw[2] = 32'h2; fw[3] = 32'h3;
      send_frame(4, 1);
      @(negedge clk);
      check("sign_A", coefsA, 64'hFFFF8000_00000001);

      // Single-beat frame.
      fw[0] = 32'h0000DEAD;
      send_frame(1, 0);

      // Random frames of length 1..6 with random gaps.
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < 8; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) != 0) fw[i] = {{16{r[15]}}, r[15:0]};
            else fw[i] = r;
         end
         if (k < 4) n = 4;
         send_frame(n, $urandom_range(0, 2));
      end

      w = 0;
      while ((exp_q.size() > 0) && (w < 10)) begin
         @(negedge clk);
         w++;
      end
      check("queue_empty", exp_q.size(), 64'd0);
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
